// File: rtl/packet_pkg.sv
// Shared packet format and transmitter types for the waveguide modulator path.
// The timestamp field is rewritten by the transmitter at launch.
package packet_pkg;

  localparam int TS_W = 32;

  typedef struct packed {
    logic [7:0]      dst;
    logic [7:0]      src;
    logic [15:0]     payload;
    logic [TS_W-1:0] timestamp;
  } packet_t;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_LAUNCH = 2'd1,
    TX_GAP    = 2'd2
  } tx_state_e;

  function automatic packet_t stamp_packet(input packet_t p, input logic [TS_W-1:0] ts);
    packet_t r;
    r = p;
    r.timestamp = ts;
    return r;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with occupancy count; push is ignored when full, pop when empty.
// Read data is the current head, valid whenever count != 0.
module tx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/waveguide_tx.sv
// Optical modulator for one waveguide direction: buffers node packets, stamps the
// launch cycle, enforces the laser inter-packet gap and bounds in-flight packets.
module waveguide_tx
  import packet_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int MAX_INFLIGHT = 4,
  parameter int GAP          = 1,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  packet_t       in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output packet_t       tx_data,
  output logic          tx_valid,
  input  logic          done_in,
  output logic [7:0]    inflight_cnt,
  output logic [CW-1:0] fifo_count,
  output logic          err_underflow,
  output tx_state_e     dbg_state
);

  // Handshake: in_data transfers on any rising edge where in_valid && in_ready;
  // in_ready depends only on registered occupancy, never on in_valid.

  localparam int              PW       = $bits(packet_t);
  localparam int              GW       = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [GW-1:0]   GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [7:0]      MAX_IF   = 8'(MAX_INFLIGHT);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  tx_state_e       state;
  logic [GW-1:0]   gap_cnt;
  logic [TS_W-1:0] cycle_cnt;
  logic [PW-1:0]   head_bits;
  packet_t         head;
  logic            fifo_empty;
  logic            slot_ok;
  logic            can_launch;
  logic            launch;

  assign in_ready   = (fifo_count != FULL_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign head       = head_bits;
  assign dbg_state  = state;

  tx_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .wdata (in_data),
    .pop   (launch),
    .rdata (head_bits),
    .count (fifo_count)
  );

  // A done pulse in the same cycle frees its slot for this launch.
  assign slot_ok    = (inflight_cnt < MAX_IF) || done_in;
  assign can_launch = !fifo_empty && slot_ok;

  // The last gap cycle doubles as the idle decision cycle, so exactly GAP
  // dead cycles separate consecutive tx_valid pulses.
  always_comb begin
    launch = 1'b0;
    case (state)
      TX_IDLE:   launch = can_launch;
      TX_LAUNCH: launch = (GAP == 0) && can_launch;
      TX_GAP:    launch = (gap_cnt == '0) && can_launch;
      default:   launch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= TX_IDLE;
      gap_cnt       <= '0;
      cycle_cnt     <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      inflight_cnt  <= '0;
      err_underflow <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      tx_valid  <= launch;
      if (launch) begin
        tx_data <= stamp_packet(head, cycle_cnt);
      end

      case (state)
        TX_IDLE: begin
          if (launch) begin
            state <= TX_LAUNCH;
          end
        end
        TX_LAUNCH: begin
          if (GAP > 0) begin
            state   <= TX_GAP;
            gap_cnt <= GAP_LOAD;
          end else if (!launch) begin
            state <= TX_IDLE;
          end
        end
        TX_GAP: begin
          if (gap_cnt == '0) begin
            state <= launch ? TX_LAUNCH : TX_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase

      // Launch and done together leave the count unchanged.
      if (launch && !done_in) begin
        inflight_cnt <= inflight_cnt + 1'b1;
      end else if (!launch && done_in && (inflight_cnt != '0)) begin
        inflight_cnt <= inflight_cnt - 1'b1;
      end
      if (done_in && (inflight_cnt == '0)) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_waveguide_tx.sv
// Directed bench for waveguide_tx: three instances cover GAP = 0, 1 and 3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_waveguide_tx;
  import packet_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  packet_t     in_data [3];
  packet_t     tx_data [3];
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  tx_valid;
  logic [2:0]  done_in;
  logic [2:0]  err_underflow;
  logic [7:0]  inflight_cnt [3];
  logic [3:0]  fifo_count [3];
  tx_state_e   dbg_state [3];

  // Reference cycle count, aligned with the DUT's free-running counter.
  logic [31:0] cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= '0;
    else      cyc <= cyc + 1;
  end

  waveguide_tx #(.DEPTH(8), .MAX_INFLIGHT(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .done_in(done_in[0]),
    .inflight_cnt(inflight_cnt[0]), .fifo_count(fifo_count[0]),
    .err_underflow(err_underflow[0]), .dbg_state(dbg_state[0]));

  waveguide_tx #(.DEPTH(8), .MAX_INFLIGHT(2), .GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .done_in(done_in[1]),
    .inflight_cnt(inflight_cnt[1]), .fifo_count(fifo_count[1]),
    .err_underflow(err_underflow[1]), .dbg_state(dbg_state[1]));

  waveguide_tx #(.DEPTH(8), .MAX_INFLIGHT(4), .GAP(3)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .done_in(done_in[2]),
    .inflight_cnt(inflight_cnt[2]), .fifo_count(fifo_count[2]),
    .err_underflow(err_underflow[2]), .dbg_state(dbg_state[2]));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic packet_t mk(input logic [15:0] pay);
    packet_t p;
    p.dst = 8'h11;
    p.src = 8'h22;
    p.payload = pay;
    p.timestamp = 32'hDEAD_BEEF;
    return p;
  endfunction

  function automatic logic [63:0] stamped(input logic [15:0] pay, input logic [31:0] ts);
    return {8'h11, 8'h22, pay, ts};
  endfunction

  task automatic check_reset(input int i, input string tag);
    check($sformatf("%s%0d_tx_valid", tag, i), tx_valid[i], 0);
    check($sformatf("%s%0d_tx_data", tag, i), tx_data[i], 0);
    check($sformatf("%s%0d_in_ready", tag, i), in_ready[i], 1);
    check($sformatf("%s%0d_inflight", tag, i), inflight_cnt[i], 0);
    check($sformatf("%s%0d_fifo_count", tag, i), fifo_count[i], 0);
    check($sformatf("%s%0d_err", tag, i), err_underflow[i], 0);
    check($sformatf("%s%0d_state", tag, i), dbg_state[i], TX_IDLE);
  endtask

  // ---------------- vector table (dut0, GAP = 0, MAX_INFLIGHT = 4) ----------------
  typedef struct {
    logic        push;
    logic [15:0] pay;
    logic        done;
    logic        exp_tv;
    logic [15:0] exp_pay;
    int          exp_ts;
    logic [7:0]  exp_if;
    logic [3:0]  exp_fc;
    logic        exp_err;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] t0;
    logic [31:0] tl;
    int acc;
    int nxt;
    int last;

    tbl[0]  = '{1'b1, 16'h0A01, 1'b0, 1'b0, 16'h0000,  0, 8'd0, 4'd1, 1'b0};
    tbl[1]  = '{1'b1, 16'h0A02, 1'b0, 1'b1, 16'h0A01,  1, 8'd1, 4'd1, 1'b0};
    tbl[2]  = '{1'b1, 16'h0A03, 1'b0, 1'b1, 16'h0A02,  2, 8'd2, 4'd1, 1'b0};
    tbl[3]  = '{1'b1, 16'h0A04, 1'b0, 1'b1, 16'h0A03,  3, 8'd3, 4'd1, 1'b0};
    tbl[4]  = '{1'b1, 16'h0A05, 1'b0, 1'b1, 16'h0A04,  4, 8'd4, 4'd1, 1'b0};
    tbl[5]  = '{1'b1, 16'h0A06, 1'b0, 1'b0, 16'h0000,  0, 8'd4, 4'd2, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000,  0, 8'd4, 4'd2, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0A05,  7, 8'd4, 4'd1, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000,  0, 8'd4, 4'd1, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000,  0, 8'd4, 4'd1, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0A06, 10, 8'd4, 4'd0, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  0, 8'd3, 4'd0, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  0, 8'd2, 4'd0, 1'b0};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  0, 8'd1, 4'd0, 1'b0};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  0, 8'd0, 4'd0, 1'b0};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  0, 8'd0, 4'd0, 1'b1};
    tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000,  0, 8'd0, 4'd0, 1'b1};

    in_valid = '0;
    done_in  = '0;
    for (int i = 0; i < 3; i++) in_data[i] = '0;

    // Reset values
    repeat (3) step();
    for (int i = 0; i < 3; i++) check_reset(i, "rst_init");
    rst = 1'b1;

    // Single packet on dut1 (GAP = 1): push at cycle 10, pulse at 12 stamped 11
    for (int g = 0; g < 30 && cyc != 32'd10; g++) step();
    in_data[1] = mk(16'h5001);
    in_valid[1] = 1'b1;
    step();
    in_valid[1] = 1'b0;
    check("single_no_early_tx", tx_valid[1], 0);
    check("single_fifo_count", fifo_count[1], 1);
    step();
    check("single_tx_valid", tx_valid[1], 1);
    check("single_tx_data", tx_data[1], stamped(16'h5001, 32'd11));
    check("single_inflight", inflight_cnt[1], 1);
    step();
    check("single_pulse_width", tx_valid[1], 0);
    // Waveguide DELAY = 4: done returns in cycle 16
    for (int g = 0; g < 10 && cyc != 32'd16; g++) step();
    done_in[1] = 1'b1;
    step();
    done_in[1] = 1'b0;
    check("single_inflight_done", inflight_cnt[1], 0);
    check("single_no_underflow", err_underflow[1], 0);

    // Table: back-to-back, done-driven launches, simultaneous done+launch, underflow
    t0 = cyc;
    for (int r = 0; r < 17; r++) begin
      in_valid[0] = tbl[r].push;
      in_data[0]  = mk(tbl[r].pay);
      done_in[0]  = tbl[r].done;
      step();
      check($sformatf("vec%0d_tx_valid", r), tx_valid[0], tbl[r].exp_tv);
      if (tbl[r].exp_tv)
        check($sformatf("vec%0d_tx_data", r), tx_data[0], stamped(tbl[r].exp_pay, t0 + 32'(tbl[r].exp_ts)));
      check($sformatf("vec%0d_inflight", r), inflight_cnt[0], tbl[r].exp_if);
      check($sformatf("vec%0d_fifo_count", r), fifo_count[0], tbl[r].exp_fc);
      check($sformatf("vec%0d_err", r), err_underflow[0], tbl[r].exp_err);
    end
    in_valid[0] = 1'b0;
    done_in[0]  = 1'b0;

    // Full FIFO on dut0: 4 launch and block, 8 fill the FIFO, 9th held
    acc = 0;
    nxt = 0;
    for (int g = 0; g < 40 && acc < 12; g++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = mk(16'hC000 + 16'(nxt));
      if (in_ready[0]) begin
        acc++;
        nxt++;
      end
      step();
    end
    in_data[0] = mk(16'hC000 + 16'(nxt));
    check("full_accepted", acc, 12);
    check("full_in_ready", in_ready[0], 0);
    check("full_fifo_count", fifo_count[0], 8);
    check("full_inflight", inflight_cnt[0], 4);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("full_hold%0d_in_ready", k), in_ready[0], 0);
      check($sformatf("full_hold%0d_tx_valid", k), tx_valid[0], 0);
    end
    done_in[0] = 1'b1;
    tl = cyc;
    check("full_push_refused", in_ready[0], 0);
    step();
    done_in[0] = 1'b0;
    check("full_pop_tx_valid", tx_valid[0], 1);
    check("full_pop_tx_data", tx_data[0], stamped(16'hC004, tl));
    check("full_pop_fifo_count", fifo_count[0], 7);
    check("full_pop_in_ready", in_ready[0], 1);
    check("full_done_launch_inflight", inflight_cnt[0], 4);
    step();
    in_valid[0] = 1'b0;
    check("full_ninth_accepted", fifo_count[0], 8);
    check("full_ninth_in_ready", in_ready[0], 0);
    step();
    check("full_inflight_hold", inflight_cnt[0], 4);
    check("err_sticky", err_underflow[0], 1);

    // Gap and ordering on dut2 (GAP = 3): pulses 4 cycles apart, in FIFO order
    t0 = cyc;
    last = -1;
    for (int g = 0; g < 20; g++) begin
      if (tx_valid[2]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL gap_extra_pulse: got tx_valid=1 expected no pulse");
        end else begin
          check("gap_tx_data", tx_data[2], exp_q.pop_front());
        end
        if (last >= 0) check("gap_spacing", cyc - 32'(last), 4);
        last = int'(cyc);
      end
      if (g < 3) begin
        in_valid[2] = 1'b1;
        in_data[2]  = mk(16'h3000 + 16'(g));
        exp_q.push_back(stamped(16'h3000 + 16'(g), t0 + 32'(1 + 4 * g)));
      end else begin
        in_valid[2] = 1'b0;
      end
      step();
    end
    check("gap_all_launched", exp_q.size(), 0);
    check("gap_inflight", inflight_cnt[2], 3);

    // Mid-stream reset on dut1 (MAX_INFLIGHT = 2): 3 queued, 2 in flight
    for (int k = 0; k < 5; k++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = mk(16'h7000 + 16'(k));
      step();
    end
    in_valid[1] = 1'b0;
    step();
    check("pre_rst_fifo_count", fifo_count[1], 3);
    check("pre_rst_inflight", inflight_cnt[1], 2);
    #2 rst = 1'b0;
    #1;
    check_reset(1, "rst_async");
    check("rst_async_err0", err_underflow[0], 0);
    step();
    check_reset(1, "rst_mid");
    rst = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
